// File: rtl/axis_multichannel_serializer.sv
// -----------------------------------------------------------------------------
// axis_multichannel_serializer
//
// Purpose:
//   Shares one NoC router injection port between NUM_CHANNELS AXI-Stream
//   producers. A round-robin arbiter grants one channel and holds that grant
//   for a whole packet, so packets are never interleaved. Each accepted beat
//   is parked in a one-beat hold register and sent as SERIALIZATION_FACTOR
//   flits, lowest slice first. Flits are sent only while the credit counter
//   (initialised to the downstream buffer depth) is non-zero.
//
// Handshake semantics:
//   AXIS side: a beat moves on a cycle where tvalid and tready are both high
//   at the rising clock edge. tready never depends on the beat being offered
//   on other channels once a lock is held. In IDLE, arbitration and tready are
//   combinational, so a beat can move on the first cycle its tvalid is high.
//   Router side: send_out is a one-cycle pulse per flit and is never held.
//   Each credit_in pulse returns exactly one flit buffer slot.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   axis_in_*        per-channel AXIS inputs, channel c in bits [c*W +: W]
//   axis_in_tready   per-channel ready, at most one bit high
//   data_out         flit payload (registered)
//   dest_out         {tid, tdest} of the beat the flit came from (registered)
//   is_tail_out      final flit of the packet (registered)
//   send_out         flit valid pulse (registered)
//   credit_in        credit return pulse from the router
//   grant_out        channel that most recently won arbitration (debug)
// -----------------------------------------------------------------------------
module axis_multichannel_serializer #(
   parameter int NUM_CHANNELS         = 4,
   parameter int TDATA_WIDTH          = 512,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int TID_WIDTH            = 2,
   parameter int TDEST_WIDTH          = 4,
   parameter int FLIT_BUFFER_DEPTH    = 4,
   localparam int FLIT_WIDTH  = TDATA_WIDTH / SERIALIZATION_FACTOR,
   localparam int DEST_WIDTH  = TID_WIDTH + TDEST_WIDTH,
   localparam int GRANT_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_CHANNELS-1:0]             axis_in_tvalid,
   output logic [NUM_CHANNELS-1:0]             axis_in_tready,
   input  logic [NUM_CHANNELS*TDATA_WIDTH-1:0] axis_in_tdata,
   input  logic [NUM_CHANNELS-1:0]             axis_in_tlast,
   input  logic [NUM_CHANNELS*TID_WIDTH-1:0]   axis_in_tid,
   input  logic [NUM_CHANNELS*TDEST_WIDTH-1:0] axis_in_tdest,
   output logic [FLIT_WIDTH-1:0]               data_out,
   output logic [DEST_WIDTH-1:0]               dest_out,
   output logic                                is_tail_out,
   output logic                                send_out,
   input  logic                                credit_in,
   output logic [GRANT_WIDTH-1:0]              grant_out
);

   localparam int IDX_WIDTH  = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam int CRED_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);

   localparam logic [IDX_WIDTH-1:0]   IDX_LAST  = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
   localparam logic [CRED_WIDTH-1:0]  CRED_MAX  = CRED_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [GRANT_WIDTH-1:0] GRANT_TOP = GRANT_WIDTH'(NUM_CHANNELS - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                  state_q,      state_d;
   logic [GRANT_WIDTH-1:0]  grant_q,      grant_d;
   logic [GRANT_WIDTH-1:0]  rr_ptr_q,     rr_ptr_d;
   logic [CRED_WIDTH-1:0]   credits_q,    credits_d;
   logic                    hold_valid_q, hold_valid_d;
   logic [TDATA_WIDTH-1:0]  hold_data_q,  hold_data_d;
   logic [DEST_WIDTH-1:0]   hold_dest_q,  hold_dest_d;
   logic                    hold_last_q,  hold_last_d;
   logic [IDX_WIDTH-1:0]    idx_q,        idx_d;
   logic                    send_out_q,   send_out_d;
   logic                    is_tail_q,    is_tail_d;
   logic [FLIT_WIDTH-1:0]   data_out_q,   data_out_d;
   logic [DEST_WIDTH-1:0]   dest_out_q,   dest_out_d;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [GRANT_WIDTH-1:0]  arb_sel;
   logic                    arb_found;
   logic [GRANT_WIDTH-1:0]  cur_grant;
   logic [GRANT_WIDTH-1:0]  next_ptr;
   logic                    link_owned;
   logic                    sel_valid;
   logic                    sel_last;
   logic [TDATA_WIDTH-1:0]  sel_data;
   logic [DEST_WIDTH-1:0]   sel_dest;
   logic [FLIT_WIDTH-1:0]   cur_flit;
   logic                    send_now;
   logic                    last_flit_now;
   logic                    can_load;
   logic                    grant_ready;
   logic                    accept;

   // Round-robin search: first valid channel at or after rr_ptr, wrapping.
   always_comb begin
      arb_sel   = rr_ptr_q;
      arb_found = 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         int c;
         c = int'(rr_ptr_q) + k;
         if (c >= NUM_CHANNELS) begin
            c = c - NUM_CHANNELS;
         end
         if (!arb_found && axis_in_tvalid[c]) begin
            arb_sel   = GRANT_WIDTH'(c);
            arb_found = 1'b1;
         end
      end
   end

   // While locked the registered grant is authoritative; in IDLE the fresh
   // arbitration result is used directly so the first beat is not delayed.
   always_comb begin
      cur_grant  = (state_q == ST_LOCKED) ? grant_q : arb_sel;
      link_owned = (state_q == ST_LOCKED) || arb_found;
      next_ptr   = (cur_grant == GRANT_TOP) ? '0 : cur_grant + GRANT_WIDTH'(1);
   end

   // Mux out the granted channel's beat.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_dest  = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (GRANT_WIDTH'(c) == cur_grant) begin
            sel_valid = axis_in_tvalid[c];
            sel_last  = axis_in_tlast[c];
            sel_data  = axis_in_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
            sel_dest  = {axis_in_tid[c*TID_WIDTH +: TID_WIDTH],
                         axis_in_tdest[c*TDEST_WIDTH +: TDEST_WIDTH]};
         end
      end
   end

   // Current flit slice of the held beat.
   always_comb begin
      cur_flit = '0;
      for (int i = 0; i < SERIALIZATION_FACTOR; i++) begin
         if (IDX_WIDTH'(i) == idx_q) begin
            cur_flit = hold_data_q[i*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   // A new beat may enter when the hold register is empty or is emptying this
   // cycle, which keeps back-to-back beats bubble-free. With no credits the
   // last flit cannot go, so tready drops automatically.
   always_comb begin
      send_now      = hold_valid_q && (credits_q != '0);
      last_flit_now = send_now && (idx_q == IDX_LAST);
      can_load      = !hold_valid_q || last_flit_now;
      grant_ready   = link_owned && can_load;
      accept        = grant_ready && sel_valid;
   end

   always_comb begin
      axis_in_tready = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (GRANT_WIDTH'(c) == cur_grant) begin
            axis_in_tready[c] = grant_ready;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Arbitration FSM: IDLE searches, LOCKED holds the grant until tlast moves.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               grant_d = arb_sel;
               // A single-beat packet accepted straight from IDLE never locks.
               if (accept && sel_last) begin
                  rr_ptr_d = next_ptr;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            if (accept && sel_last) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Hold register, flit sequencing and registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_dest_d  = hold_dest_q;
      hold_last_d  = hold_last_q;
      idx_d        = idx_q;
      send_out_d   = 1'b0;
      is_tail_d    = 1'b0;
      data_out_d   = data_out_q;
      dest_out_d   = dest_out_q;

      if (send_now) begin
         send_out_d = 1'b1;
         data_out_d = cur_flit;
         dest_out_d = hold_dest_q;
         is_tail_d  = last_flit_now && hold_last_q;
         if (last_flit_now) begin
            hold_valid_d = 1'b0;
            idx_d        = '0;
         end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
         end
      end

      // A load in the same cycle as the last flit overrides the emptying above.
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = sel_data;
         hold_dest_d  = sel_dest;
         hold_last_d  = sel_last;
         idx_d        = '0;
      end
   end

   // Credit counter: a send and a returned credit in one cycle cancel out.
   // A return into a full counter is dropped rather than wrapping.
   always_comb begin
      credits_d = credits_q;
      case ({send_now, credit_in})
         2'b10:   credits_d = credits_q - CRED_WIDTH'(1);
         2'b01:   credits_d = (credits_q == CRED_MAX) ? credits_q : credits_q + CRED_WIDTH'(1);
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         credits_q    <= CRED_MAX;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_dest_q  <= '0;
         hold_last_q  <= 1'b0;
         idx_q        <= '0;
         send_out_q   <= 1'b0;
         is_tail_q    <= 1'b0;
         data_out_q   <= '0;
         dest_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         credits_q    <= credits_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_dest_q  <= hold_dest_d;
         hold_last_q  <= hold_last_d;
         idx_q        <= idx_d;
         send_out_q   <= send_out_d;
         is_tail_q    <= is_tail_d;
         data_out_q   <= data_out_d;
         dest_out_q   <= dest_out_d;
      end
   end

   assign send_out    = send_out_q;
   assign is_tail_out = is_tail_q;
   assign data_out    = data_out_q;
   assign dest_out    = dest_out_q;
   assign grant_out   = grant_q;

`ifndef SYNTHESIS
   // The router must never return more credits than it has buffer slots.
   credit_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
      !(credit_in && !send_now && (credits_q == CRED_MAX)))
      else $error("credit_in returned while credit counter already full");
`endif

endmodule

// File: tb/tb_axis_multichannel_serializer.sv
`timescale 1ns/1ps
module tb_axis_multichannel_serializer;

  localparam int NCH   = 4;
  localparam int TW    = 512;
  localparam int SF    = 4;
  localparam int IDW   = 2;
  localparam int TDW   = 4;
  localparam int DEPTH = 4;
  localparam int FW    = TW / SF;
  localparam int DW    = IDW + TDW;
  localparam int GW    = 2;
  localparam int EW    = 1 + DW + FW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]     axis_in_tvalid;
  logic [NCH-1:0]     axis_in_tready;
  logic [NCH*TW-1:0]  axis_in_tdata;
  logic [NCH-1:0]     axis_in_tlast;
  logic [NCH*IDW-1:0] axis_in_tid;
  logic [NCH*TDW-1:0] axis_in_tdest;
  logic [FW-1:0]      data_out;
  logic [DW-1:0]      dest_out;
  logic               is_tail_out;
  logic               send_out;
  logic               credit_in;
  logic [GW-1:0]      grant_out;

  logic           tb_valid [NCH];
  logic           tb_last  [NCH];
  logic [TW-1:0]  tb_data  [NCH];
  logic [IDW-1:0] tb_id    [NCH];
  logic [TDW-1:0] tb_dest  [NCH];

  logic credit_drv;
  logic loop_en;
  assign credit_in = (loop_en & send_out) | credit_drv;

  always_comb begin
    axis_in_tvalid = '0;
    axis_in_tlast  = '0;
    axis_in_tdata  = '0;
    axis_in_tid    = '0;
    axis_in_tdest  = '0;
    for (int c = 0; c < NCH; c++) begin
      axis_in_tvalid[c]            = tb_valid[c];
      axis_in_tlast[c]             = tb_last[c];
      axis_in_tdata[c*TW +: TW]    = tb_data[c];
      axis_in_tid[c*IDW +: IDW]    = tb_id[c];
      axis_in_tdest[c*TDW +: TDW]  = tb_dest[c];
    end
  end

  axis_multichannel_serializer #(
    .NUM_CHANNELS(NCH), .TDATA_WIDTH(TW), .SERIALIZATION_FACTOR(SF),
    .TID_WIDTH(IDW), .TDEST_WIDTH(TDW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .grant_out(grant_out)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            acc_ch[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            send_cnt = 0;
  logic [EW-1:0] mon_exp;

  always @(negedge clk) begin
    if (rst_n && send_out) begin
      send_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_flit: got %0h, expected no flit", {is_tail_out, dest_out, data_out});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({is_tail_out, dest_out, data_out} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_flit: got tail=%0b dest=%0h data=%0h, expected tail=%0b dest=%0h data=%0h",
                   is_tail_out, dest_out, data_out, mon_exp[EW-1], mon_exp[EW-2 -: DW], mon_exp[FW-1:0]);
        end
      end
    end
  end

  // driver tasks
  function automatic logic [TW-1:0] rand_beat();
    logic [TW-1:0] d;
    for (int w = 0; w < TW/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    credit_drv = 1'b0;
    loop_en    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      tb_valid[c] = 1'b0; tb_last[c] = 1'b0; tb_data[c] = '0; tb_id[c] = '0; tb_dest[c] = '0;
    end
    exp_q.delete();
    acc_ch.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_credit();
    @(negedge clk);
    credit_drv = 1'b1;
    @(negedge clk);
    credit_drv = 1'b0;
  endtask

  task automatic drive_packet(input int ch, input int nbeats, input logic [IDW-1:0] tid,
                              input logic [TDW-1:0] tdest, input logic [TW-1:0] fixed, input logic use_fixed);
    for (int b = 0; b < nbeats; b++) begin
      logic [TW-1:0] d;
      logic          acc;
      logic          last;
      int            waited;
      d    = use_fixed ? fixed : rand_beat();
      last = (b == nbeats - 1);
      @(negedge clk);
      tb_valid[ch] = 1'b1; tb_data[ch] = d; tb_last[ch] = last; tb_id[ch] = tid; tb_dest[ch] = tdest;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 400) begin
        #1;
        if (axis_in_tready[ch]) begin
          @(posedge clk);
          acc = 1'b1;
          acc_ch.push_back(ch);
          for (int i = 0; i < SF; i++) begin
            logic tail;
            tail = (i == SF - 1) && last;
            exp_q.push_back({tail, tid, tdest, d[i*FW +: FW]});
          end
          #1;
          n_checks++;
          if (grant_out !== GW'(ch)) begin
            n_fail++;
            $display("FAIL grant_on_accept: got %0d, expected %0d", grant_out, ch);
          end
        end else begin
          @(negedge clk);
          waited++;
        end
      end
      if (!acc) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: channel %0d beat %0d never accepted", ch, b);
      end
    end
    @(negedge clk);
    tb_valid[ch] = 1'b0;
    tb_last[ch]  = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d flits outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({send_out, is_tail_out, data_out, dest_out, axis_in_tready, grant_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got send=%0b tail=%0b data=%0h dest=%0h rdy=%0b grant=%0d, expected all 0",
               send_out, is_tail_out, data_out, dest_out, axis_in_tready, grant_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (send_cnt !== 0 || axis_in_tready !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: got sends=%0d rdy=%0b, expected 0 and 0", send_cnt, axis_in_tready);
    end
  endtask

  task automatic test_single_beat();
    logic [TW-1:0] d;
    int            waited;
    do_reset();
    loop_en = 1'b1;
    d = '0;
    for (int i = 0; i < SF; i++) d[i*FW +: FW] = FW'(i);
    drive_packet(2, 1, 2'd1, 4'd5, d, 1'b1);
    waited = 0;
    do begin
      @(negedge clk); #1; waited++;
    end while (!send_out && waited < 20);
    for (int i = 0; i < SF; i++) begin
      n_checks++;
      if (send_out !== 1'b1 || data_out !== FW'(i) || dest_out !== 6'h15 || is_tail_out !== (i == SF - 1)) begin
        n_fail++;
        $display("FAIL single_beat_flit%0d: got send=%0b data=%0h dest=%0h tail=%0b, expected 1 %0h 15 %0b",
                 i, send_out, data_out, dest_out, is_tail_out, i, (i == SF - 1));
      end
      @(negedge clk); #1;
    end
    n_checks++;
    if (send_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_beat_end: got send=%0b, expected 0", send_out);
    end
    check_drained("single_beat");
  endtask

  task automatic test_arbitration();
    do_reset();
    loop_en = 1'b1;
    fork
      drive_packet(0, 2, 2'd0, 4'd1, '0, 1'b0);
      drive_packet(3, 2, 2'd3, 4'd9, '0, 1'b0);
    join
    repeat (20) @(negedge clk);
    n_checks++;
    if (acc_ch.size() != 4 || acc_ch[0] != 0 || acc_ch[1] != 0 || acc_ch[2] != 3 || acc_ch[3] != 3) begin
      n_fail++;
      $display("FAIL arb_order: got %p, expected '{0,0,3,3}", acc_ch);
    end
    check_drained("arb");
    // pointer wrapped to 0 after channel 3 finished
    acc_ch.delete();
    fork
      drive_packet(3, 1, 2'd2, 4'd2, '0, 1'b0);
      drive_packet(0, 1, 2'd1, 4'd7, '0, 1'b0);
    join
    repeat (20) @(negedge clk);
    n_checks++;
    if (acc_ch.size() != 2 || acc_ch[0] != 0 || acc_ch[1] != 3) begin
      n_fail++;
      $display("FAIL arb_wrap: got %p, expected '{0,3}", acc_ch);
    end
    check_drained("arb_wrap");
  endtask

  task automatic test_credit_stall();
    do_reset();
    send_cnt = 0;
    fork
      drive_packet(1, 3, 2'd2, 4'd3, '0, 1'b0);
      begin
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (send_cnt !== DEPTH) begin
          n_fail++;
          $display("FAIL stall_count: got %0d flits, expected %0d", send_cnt, DEPTH);
        end
        n_checks++;
        if (axis_in_tready[1] !== 1'b0 || axis_in_tvalid[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ready: got rdy=%0b vld=%0b, expected 0 and 1", axis_in_tready[1], axis_in_tvalid[1]);
        end
        pulse_credit();
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (send_cnt !== DEPTH + 1) begin
          n_fail++;
          $display("FAIL one_credit: got %0d flits, expected %0d", send_cnt, DEPTH + 1);
        end
        repeat (7) pulse_credit();
        repeat (10) @(negedge clk);
      end
    join
    #1;
    n_checks++;
    if (send_cnt !== 12) begin
      n_fail++;
      $display("FAIL stall_total: got %0d flits, expected 12", send_cnt);
    end
    check_drained("stall");
  endtask

  task automatic test_back_to_back();
    int gaps;
    int waited;
    do_reset();
    send_cnt = 0;
    gaps = 0;
    fork
      drive_packet(1, 4, 2'd1, 4'd14, '0, 1'b0);
      begin
        waited = 0;
        while (send_cnt < 3 && waited < 100) begin
          @(negedge clk); #1; waited++;
        end
        loop_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
          @(negedge clk); #1;
          if (send_out !== 1'b1) gaps++;
        end
        @(negedge clk);
        loop_en = 1'b0;
      end
    join
    n_checks++;
    if (gaps != 0 || send_cnt !== 16) begin
      n_fail++;
      $display("FAIL b2b_throughput: got gaps=%0d flits=%0d, expected 0 and 16", gaps, send_cnt);
    end
    check_drained("b2b");
    // one credit in flight, plus the final returned credit, leaves exactly 2
    send_cnt = 0;
    fork
      drive_packet(2, 1, 2'd0, 4'd0, '0, 1'b0);
      begin
        repeat (15) @(negedge clk);
        #1;
        n_checks++;
        if (send_cnt !== 2) begin
          n_fail++;
          $display("FAIL b2b_residual_credit: got %0d flits, expected 2", send_cnt);
        end
        repeat (2) pulse_credit();
        repeat (8) @(negedge clk);
      end
    join
    check_drained("b2b_residual");
  endtask

  task automatic test_reset_mid_packet();
    int waited;
    do_reset();
    loop_en  = 1'b1;
    send_cnt = 0;
    drive_packet(2, 1, 2'd3, 4'd15, '0, 1'b0);
    waited = 0;
    while (send_cnt < 2 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({send_out, is_tail_out, data_out, dest_out, axis_in_tready} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got send=%0b tail=%0b data=%0h dest=%0h rdy=%0b, expected all 0",
               send_out, is_tail_out, data_out, dest_out, axis_in_tready);
    end
    exp_q.delete();
    loop_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_cnt = 0;
    drive_packet(1, 1, 2'd2, 4'd6, '0, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    n_checks++;
    if (send_cnt !== DEPTH) begin
      n_fail++;
      $display("FAIL post_reset_credits: got %0d flits, expected %0d", send_cnt, DEPTH);
    end
    check_drained("post_reset");
  endtask

  initial begin
    credit_drv = 1'b0;
    loop_en    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      tb_valid[c] = 1'b0; tb_last[c] = 1'b0; tb_data[c] = '0; tb_id[c] = '0; tb_dest[c] = '0;
    end
    test_reset();
    test_single_beat();
    test_arbitration();
    test_credit_stall();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
